// File: rtl/nf10_input_arbiter_pkg.sv
// Shared constants for the ingress arbiter: FSM encoding, tuser field offsets
// and the per-input FIFO sizing.
package nf10_input_arbiter_pkg;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] WR_PKT = 1'b1;

    localparam int unsigned SRC_POS = 16;
    localparam int unsigned DST_POS = 24;

    localparam int unsigned IN_FIFO_DEPTH_BIT = 2;

    // Ceiling log2, minimum result 0.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/nf10_input_arbiter_if.sv
// AXI4-Stream bundle used for the arbiter's slave inputs and merged master output.
interface nf10_input_arbiter_if #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_input_arbiter_fallthrough_small_fifo.sv
// Small fall-through FIFO: the head word is visible on dout whenever empty is low.
module nf10_input_arbiter_fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_CNT = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   depth_q;
    logic                      wr_ok, rd_ok;

    assign wr_ok       = wr_en & (depth_q != FULL_CNT);
    assign rd_ok       = rd_en & (depth_q != '0);
    assign empty       = (depth_q == '0);
    assign nearly_full = (depth_q >= NEARLY_CNT);
    assign dout        = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   depth_q <= depth_q + 1'b1;
                2'b01:   depth_q <= depth_q - 1'b1;
                default: depth_q <= depth_q;
            endcase
        end
    end
endmodule

// File: rtl/nf10_input_arbiter.sv
// Packet-granular round-robin merge of five AXI4-Stream inputs onto one output.
// Optional macro NF10_INPUT_ARB_SRC_STAMP_EN stamps the one-hot source port into tuser.
module nf10_input_arbiter
    import nf10_input_arbiter_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_QUEUES           = 5
) (
    input logic                  axi_aclk,
    input logic                  axi_resetn,
    nf10_input_arbiter_if.slave  s_axis_0,
    nf10_input_arbiter_if.slave  s_axis_1,
    nf10_input_arbiter_if.slave  s_axis_2,
    nf10_input_arbiter_if.slave  s_axis_3,
    nf10_input_arbiter_if.slave  s_axis_4,
    nf10_input_arbiter_if.master m_axis
);
    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned FW = 1 + UW + SW + DW;
    localparam int unsigned QW = log2(NUM_QUEUES);

    logic [FW-1:0]         fifo_din  [NUM_QUEUES];
    logic [FW-1:0]         fifo_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] s_tvalid, s_tready, wr_en, rd_en, nearly_full, empty;

    assign fifo_din[0] = {s_axis_0.tlast, s_axis_0.tuser, s_axis_0.tstrb, s_axis_0.tdata};
    assign fifo_din[1] = {s_axis_1.tlast, s_axis_1.tuser, s_axis_1.tstrb, s_axis_1.tdata};
    assign fifo_din[2] = {s_axis_2.tlast, s_axis_2.tuser, s_axis_2.tstrb, s_axis_2.tdata};
    assign fifo_din[3] = {s_axis_3.tlast, s_axis_3.tuser, s_axis_3.tstrb, s_axis_3.tdata};
    assign fifo_din[4] = {s_axis_4.tlast, s_axis_4.tuser, s_axis_4.tstrb, s_axis_4.tdata};
    assign s_tvalid = {s_axis_4.tvalid, s_axis_3.tvalid, s_axis_2.tvalid,
                       s_axis_1.tvalid, s_axis_0.tvalid};
    assign s_axis_0.tready = s_tready[0];
    assign s_axis_1.tready = s_tready[1];
    assign s_axis_2.tready = s_tready[2];
    assign s_axis_3.tready = s_tready[3];
    assign s_axis_4.tready = s_tready[4];

    // Ready is gated by reset so no input is acknowledged while the FIFOs are held clear.
    assign s_tready = {NUM_QUEUES{axi_resetn}} & ~nearly_full;
    assign wr_en    = s_tvalid & s_tready;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_in_fifo
        nf10_input_arbiter_fallthrough_small_fifo #(
            .WIDTH          (FW),
            .MAX_DEPTH_BITS (IN_FIFO_DEPTH_BIT)
        ) u_fifo (
            .clk         (axi_aclk),
            .reset_n     (axi_resetn),
            .din         (fifo_din[g]),
            .wr_en       (wr_en[g]),
            .rd_en       (rd_en[g]),
            .dout        (fifo_dout[g]),
            .nearly_full (nearly_full[g]),
            .empty       (empty[g])
        );
    end

    // Returns {found, queue}: first non-empty queue after last, wrapping.
    function automatic logic [QW:0] next_queue(input logic [NUM_QUEUES-1:0] nonempty,
                                               input logic [QW-1:0] last);
        logic [QW-1:0] idx;
        logic [QW:0]   res;
        res = '0;
        for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
            idx = QW'((32'(last) + i) % NUM_QUEUES);
            if (!res[QW] && nonempty[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [0:0]    state_q, state_d;
    logic [QW-1:0] cur_q, cur_d, last_q, last_d, pick_q;
    logic          pick_found, m_valid;
    logic          head_last;
    logic [UW-1:0] head_user;
    logic [SW-1:0] head_strb;
    logic [DW-1:0] head_data;

    assign {pick_found, pick_q} = next_queue(~empty, last_q);
    assign {head_last, head_user, head_strb, head_data} = fifo_dout[cur_q];

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        rd_en   = '0;
        m_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    cur_d   = pick_q;
                    state_d = WR_PKT;
                end
            end
            WR_PKT: begin
                m_valid = !empty[cur_q];
                if (m_valid && m_axis.tready) begin
                    rd_en[cur_q] = 1'b1;
                    if (head_last) begin
                        last_d  = cur_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= QW'(NUM_QUEUES - 1);
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = head_data;
    assign m_axis.tstrb  = head_strb;
    assign m_axis.tlast  = head_last;

`ifdef NF10_INPUT_ARB_SRC_STAMP_EN
    // MAC ports occupy the even bits of the source field; DMA takes bit 1.
    function automatic logic [7:0] src_onehot(input logic [QW-1:0] q);
        return (q == QW'(4)) ? 8'h02 : (8'h01 << {q, 1'b0});
    endfunction

    always_comb begin
        m_axis.tuser                = head_user;
        m_axis.tuser[SRC_POS +: 8]  = src_onehot(cur_q);
    end
`else
    assign m_axis.tuser = head_user;
`endif
endmodule

// File: doc/nf10_input_arbiter.md
# nf10_input_arbiter

Packet-granular round-robin merger at the ingress of the datapath. It takes NUM_QUEUES AXI4-Stream slave ports (4 MAC + 1 DMA) and merges them onto one master stream that feeds the lookup/output-queue stage. Each input has a small fall-through buffer. Packets are never interleaved on the output. Optionally, the source-port one-hot field in tuser is stamped with the input the packet arrived on.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master tdata width.
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal the master width.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal the master width.
- NUM_QUEUES, 5, number of slave ports; fixed at 5 by the port list.
- axi_aclk  in  1  single clock; all logic is on its rising edge.
- axi_resetn  in  1  asynchronous active-low reset.
- s_axis_tdata_i / tstrb_i / tuser_i / tvalid_i / tlast_i  in  DW / DW/8 / UW / 1 / 1  slave stream i, for i = 0..4.
- s_axis_tready_i  out  1  slave i ready.
- m_axis_tdata / tstrb / tuser / tvalid / tlast  out  DW / DW/8 / UW / 1 / 1  merged master stream.
- m_axis_tready  in  1  downstream ready.

## Operation
- Per input: fall-through FIFO with depth 4 (depth bits 2), holding {tlast, tuser, tstrb, tdata}.
  - wr_en_i = s_axis_tvalid_i & s_axis_tready_i.
  - s_axis_tready_i = !nearly_full_i.
- State machine states:
  - IDLE: scan FIFOs for non-empty, starting at (last_q+1) mod 5 and wrapping. The first non-empty FIFO found becomes cur_q and the state moves to WR_PKT. If all FIFOs are empty, stay in IDLE.
  - WR_PKT:
    - m_axis_tvalid = !empty[cur_q]; the master stream carries the head word of FIFO cur_q.
    - rd_en[cur_q] = m_axis_tvalid & m_axis_tready.
    - When a word with tlast is accepted: last_q <= cur_q, state -> IDLE.
- m_axis_tvalid is 0 in IDLE. tdata/tstrb/tuser/tlast are don't-care whenever tvalid is 0.
- Output data is never reordered within a packet, and packets from different inputs are never interleaved.
- If a FIFO goes empty mid-packet, stay in WR_PKT with tvalid low and do not switch inputs.
- A zero-length stall on the output (tready low) holds all state.
- tuser passes through unchanged, except as described in Configuration.

## Timing
- Reset values: state = IDLE, last_q = 4 (so queue 0 has highest priority first), cur_q = 0, all FIFOs empty, m_axis_tvalid = 0.
  - While axi_resetn is low, every s_axis_tready_i is forced to 0.
  - On the first cycle after release, every s_axis_tready_i = 1.
- Latency: a word accepted on s_axis_i at cycle t with the arbiter in IDLE and all other FIFOs empty is presented on m_axis at t+2 (t+1 FIFO write, t+1 IDLE decision, t+2 WR_PKT).
- Arbitration costs one IDLE bubble cycle between consecutive packets.
- A single-word packet (tlast on the first word) is accepted in WR_PKT and returns to IDLE on the next cycle.
- Reset mid-packet: the asynchronous clear drops all buffered and partial data. The next packet starts cleanly in IDLE with no partial output.
- Simultaneous tlast acceptance and new arrivals: the new arrivals are considered in the following IDLE cycle using the updated last_q.

## Configuration
- Macro: NF10_INPUT_ARB_SRC_STAMP_EN.
- Defined:
  - On the master stream, tuser[23:16] is replaced by a one-hot source port. Input i for i = 0..3 sets bit 16+2i. Input 4 (DMA) sets bit 17.
  - All other tuser bits pass through unchanged.
- Undefined: tuser passes through bit-exact.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, WR_PKT=1);
  - SRC_POS=16 and DST_POS=24 tuser field offsets;
  - the log2 function;
  - the input FIFO depth constant (2 bits).
- One natural sub-module: the existing fallthrough_small_fifo, instantiated once per input.
- Round-robin next-queue selection is a combinational function in the arbiter itself and is not a separate module.

## Test plan
- Single packet: 3-word packet on input 2, m_axis_tready=1. Expect it on m_axis starting 2 cycles after the first accept, tlast on word 3, words identical.
- Fairness: all 5 inputs continuously send 2-word packets. Expect output packet order 0,1,2,3,4,0,…, with one bubble cycle between packets.
- Backpressure: m_axis_tready toggles 1010 during a 6-word packet on input 0.
  - No data loss or duplication.
  - s_axis_tready_0 drops after 3 buffered words (nearly_full).
  - A packet arriving on input 1 is not emitted until input 0's tlast.
- Source stamping with the macro defined: a packet on input 4 with tuser[23:16]=0x00 leaves with tuser[23:16]=0x02. A packet on input 3 leaves with 0x40. Without the macro, tuser is unchanged.
- Reset mid-packet: assert axi_resetn low during word 2 of a 4-word packet on input 1.
  - m_axis_tvalid = 0 and all s_axis_tready = 0 during reset.
  - After release, a new packet on input 1 is output intact, with no stale words.
